// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enable/flush control for the 5-stage CPU.
// Resolves load-use stalls, taken-branch flushes and data-memory waits, and traps
// memory accesses that stay stuck in WAIT for longer than MEM_TIMEOUT cycles.
// Optional performance counters are built only when HAZ_PERF_EN is defined;
// otherwise stall_cycles/flush_count are tied to zero.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W       = 5,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] ex_rw,
   input  logic             ex_is_load,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   // Wide enough to hold MEM_TIMEOUT itself; the counter never goes past it.
   localparam int unsigned WcW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WcW-1:0] WcMax = WcW'(MEM_TIMEOUT);
   localparam logic [WcW-1:0] WcOne = WcW'(1);

   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StWait = 2'd1,
      StErr  = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
   logic           mem_err_q, mem_err_d;

   logic rs_hit;
   logic rt_hit;
   logic lu;
   logic memstall;
   logic in_err;

   // Hazard detection on the raw stage information.
   always_comb begin
      rs_hit   = id_use_rs & (id_rs == ex_rw);
      rt_hit   = id_use_rt & (id_rt == ex_rw);
      lu       = ex_is_load & (ex_rw != '0) & (rs_hit | rt_hit);
      memstall = mem_req & ~mem_ready;
      in_err   = (state_q == StErr);
   end

   // Pipeline controls: ERR > memstall > branch flush > load-use.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_en      = 1'b1;
      idex_flush   = 1'b0;
      exmem_en     = 1'b1;
      memwb_bubble = 1'b0;
      if (in_err || memstall) begin
         // Freeze everything upstream of MEM; MEM/WB drains a bubble.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (br_taken) begin
         // IF and ID hold wrong-path instructions, so any load-use on ID is moot.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu) begin
         // Hold PC and IF/ID one cycle, insert a single bubble into EX.
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // Memory-wait watchdog: next state, wait counter and sticky trap flag.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      unique case (state_q)
         StRun: begin
            if (memstall) begin
               state_d    = StWait;
               wait_cnt_d = WcOne;
            end
         end
         StWait: begin
            if (!memstall) begin
               // Ready seen, or the request went away: the pipeline moves this cycle.
               state_d    = StRun;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WcMax) begin
               state_d   = StErr;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WcOne;
            end
         end
         StErr: begin
            // Only reset leaves ERR.
            state_d   = StErr;
            mem_err_d = 1'b1;
         end
         default: begin
            state_d    = StRun;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Watchdog state registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

`ifdef HAZ_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   // Saturating counters: stalled cycles (pc held) and accepted branch flushes.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!pc_en && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_q != '1)) begin
         flush_d = flush_q + CNT_W'(1);
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
